seg_scan_ctrl: RTL and testbench

Four-digit multiplexed scan controller for the 7-segment display. It takes a 16-bit hex value from the application logic and double-buffers it so updates land only at frame boundaries. Each cycle it presents one nibble to the downstream 4-bit segment decoder and drives the matching active-low digit anode. Each digit slot starts with a ghost-suppression blank interval, and leading-zero blanking is optional.

---
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Application-side bus of the 7-segment scan controller: the value/load strobe in,
// the decoder nibble, the anodes and the status pulses out.
interface seg_scan_ctrl_if;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  D;
    logic [3:0]  an;
    logic        upd_ack;
    logic        frame_done;

    modport master (
        output value, load, blank_lz,
        input  D, an, upd_ack, frame_done
    );

    modport slave (
        input  value, load, blank_lz,
        output D, an, upd_ack, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a double-buffered value,
// a per-slot ghost-suppression blank interval and optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned CW         = $clog2(REFRESH_DIV);
    localparam int unsigned BLANK_LAST = (BLANK_CYC == 0) ? 0 : BLANK_CYC - 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_LAST);

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

    localparam phase_e SLOT_START = (BLANK_CYC == 0) ? PH_ON : PH_BLANK;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    phase_e        phase_q, phase_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    d_q, d_d;
    logic [3:0]    an_q, an_d;
    logic          upd_ack_q, upd_ack_d;
    logic          frame_done_q, frame_done_d;

    logic slot_end;
    logic boundary;
    logic lz_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            dig_q        <= '0;
            phase_q      <= SLOT_START;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            d_q          <= '0;
            an_q         <= '1;
            upd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            phase_q      <= phase_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            d_q          <= d_d;
            an_q         <= an_d;
            upd_ack_q    <= upd_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Slot counter, digit index and blank/on phase
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        dig_d    = dig_q;
        phase_d  = phase_q;
        slot_end = (cnt_q == CNT_MAX);
        boundary = slot_end && (dig_q == 2'd3);
        if (slot_end) begin
            cnt_d   = '0;
            dig_d   = dig_q + 2'd1;
            phase_d = SLOT_START;
        end else if (phase_q == PH_BLANK && cnt_q == BLANK_END) begin
            phase_d = PH_ON;
        end
    end

    // A load on the boundary bypasses the pending buffer and supersedes it
    always_comb begin
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        upd_ack_d    = 1'b0;
        frame_done_d = boundary;
        if (bus.load) begin
            if (boundary) begin
                disp_d    = bus.value;
                pend_v_d  = 1'b0;
                upd_ack_d = 1'b1;
            end else begin
                pend_d   = bus.value;
                pend_v_d = 1'b1;
            end
        end else if (boundary && pend_v_q) begin
            disp_d    = pend_q;
            pend_v_d  = 1'b0;
            upd_ack_d = 1'b1;
        end
    end

    always_comb begin
        d_d      = '0;
        lz_blank = 1'b0;
        case (dig_q)
            2'd0: d_d = disp_q[3:0];
            2'd1: begin
                d_d      = disp_q[7:4];
                lz_blank = (disp_q[15:4] == '0);
            end
            2'd2: begin
                d_d      = disp_q[11:8];
                lz_blank = (disp_q[15:8] == '0);
            end
            default: begin
                d_d      = disp_q[15:12];
                lz_blank = (disp_q[15:12] == '0);
            end
        endcase
        if (phase_q == PH_BLANK || (bus.blank_lz && lz_blank)) begin
            an_d = '1;
        end else begin
            an_d = ~(4'b0001 << dig_q);
        end
    end

    assign bus.D          = d_q;
    assign bus.an         = an_q;
    assign bus.upd_ack    = upd_ack_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a cycle-position model derived from elapsed time since reset,
// checked every cycle, plus literal spot checks of the documented scenarios.
module tb_seg_scan_ctrl;
    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cur = 0;

    // Model state: t is the number of cycles since reset release.
    int unsigned t_m = 0;
    logic [15:0] disp_m = '0;
    logic [15:0] pend_m = '0;
    logic        pv_m = 1'b0;
    logic [3:0]  exp_d = '0;
    logic [3:0]  exp_an = '1;
    logic        exp_ua = 1'b0;
    logic        exp_fd = 1'b0;
    logic        model_ok = 1'b0;

    function automatic logic [3:0] anode_for(int unsigned pos, int unsigned dg,
                                             logic [15:0] v, logic lz);
        logic [15:0] upper;
        if (pos < BC) return 4'b1111;
        upper = v >> (4 * dg);
        if (lz && dg != 0 && upper == 16'h0) return 4'b1111;
        return ~(4'b0001 << dg);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t_m = 0; disp_m = '0; pend_m = '0; pv_m = 1'b0;
                exp_d = '0; exp_an = '1; exp_ua = 1'b0; exp_fd = 1'b0;
            end else begin
                int unsigned pos, dg;
                logic bnd;
                pos = t_m % RD;
                dg  = (t_m / RD) % 4;
                bnd = ((t_m % (4 * RD)) == 4 * RD - 1);
                exp_d  = 4'((disp_m >> (4 * dg)) & 16'hF);
                exp_an = anode_for(pos, dg, disp_m, bus.blank_lz);
                exp_fd = bnd;
                exp_ua = bnd && (bus.load || pv_m);
                if (bus.load) begin
                    if (bnd) begin disp_m = bus.value; pv_m = 1'b0; end
                    else begin pend_m = bus.value; pv_m = 1'b1; end
                end else if (bnd && pv_m) begin
                    disp_m = pend_m; pv_m = 1'b0;
                end
                t_m++;
            end
            model_ok = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                vectors++;
                if (bus.D !== exp_d) begin
                    miscompares++;
                    $display("FAIL model_D t=%0t got %h expected %h", $time, bus.D, exp_d);
                end
                vectors++;
                if (bus.an !== exp_an) begin
                    miscompares++;
                    $display("FAIL model_an t=%0t got %b expected %b", $time, bus.an, exp_an);
                end
                vectors++;
                if (bus.upd_ack !== exp_ua) begin
                    miscompares++;
                    $display("FAIL model_upd_ack t=%0t got %b expected %b", $time, bus.upd_ack, exp_ua);
                end
                vectors++;
                if (bus.frame_done !== exp_fd) begin
                    miscompares++;
                    $display("FAIL model_frame_done t=%0t got %b expected %b", $time, bus.frame_done, exp_fd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
    endtask

    task automatic run_to(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic load_at(input int c, input logic [15:0] v);
        run_to(c);
        bus.value = v;
        bus.load  = 1'b1;
        run_to(c + 1);
        bus.load  = 1'b0;
    endtask

    initial begin
        bus.value = '0;
        bus.load = 1'b0;
        bus.blank_lz = 1'b0;

        // Idle scan after reset
        do_reset();
        chk("idle_an_c0", 16'(bus.an), 16'h000F);
        chk("idle_d_c0", 16'(bus.D), 16'h0000);
        run_to(3);
        chk("idle_an_c3", 16'(bus.an), 16'h000E);
        run_to(11);
        chk("idle_an_c11", 16'(bus.an), 16'h000D);
        run_to(32);
        chk("idle_fd_c32", 16'(bus.frame_done), 16'h0001);
        chk("idle_ua_c32", 16'(bus.upd_ack), 16'h0000);
        run_to(33);
        chk("idle_fd_c33", 16'(bus.frame_done), 16'h0000);

        // Mid-frame load lands at the boundary
        do_reset();
        load_at(5, 16'h1A2F);
        run_to(31);
        chk("mid_d_c31", 16'(bus.D), 16'h0000);
        run_to(32);
        chk("mid_ua_c32", 16'(bus.upd_ack), 16'h0001);
        run_to(35);
        chk("mid_d_c35", 16'(bus.D), 16'h000F);
        chk("mid_an_c35", 16'(bus.an), 16'h000E);
        run_to(43);
        chk("mid_d_c43", 16'(bus.D), 16'h0002);
        chk("mid_an_c43", 16'(bus.an), 16'h000D);
        run_to(51);
        chk("mid_d_c51", 16'(bus.D), 16'h000A);
        chk("mid_an_c51", 16'(bus.an), 16'h000B);
        run_to(59);
        chk("mid_d_c59", 16'(bus.D), 16'h0001);
        chk("mid_an_c59", 16'(bus.an), 16'h0007);
        run_to(64);
        chk("mid_ua_c64", 16'(bus.upd_ack), 16'h0000);

        // Last write wins
        do_reset();
        load_at(5, 16'h1111);
        load_at(9, 16'h2222);
        run_to(32);
        chk("lww_ua_c32", 16'(bus.upd_ack), 16'h0001);
        run_to(35);
        chk("lww_d_c35", 16'(bus.D), 16'h0002);
        run_to(66);

        // Load on the boundary supersedes the pending value
        do_reset();
        load_at(10, 16'h1234);
        load_at(31, 16'hBEEF);
        run_to(32);
        chk("bnd_ua_c32", 16'(bus.upd_ack), 16'h0001);
        run_to(35);
        chk("bnd_d_c35", 16'(bus.D), 16'h000F);
        run_to(59);
        chk("bnd_d_c59", 16'(bus.D), 16'h000B);
        run_to(64);
        chk("bnd_ua_c64", 16'(bus.upd_ack), 16'h0000);
        run_to(99);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        do_reset();
        load_at(31, 16'h0040);
        run_to(35);
        chk("lz_d_c35", 16'(bus.D), 16'h0000);
        chk("lz_an_c35", 16'(bus.an), 16'h000E);
        run_to(43);
        chk("lz_d_c43", 16'(bus.D), 16'h0004);
        chk("lz_an_c43", 16'(bus.an), 16'h000D);
        run_to(51);
        chk("lz_an_c51", 16'(bus.an), 16'h000F);
        run_to(59);
        chk("lz_an_c59", 16'(bus.an), 16'h000F);
        load_at(63, 16'h0000);
        run_to(67);
        chk("lz0_an_c67", 16'(bus.an), 16'h000E);
        chk("lz0_d_c67", 16'(bus.D), 16'h0000);
        run_to(75);
        chk("lz0_an_c75", 16'(bus.an), 16'h000F);
        run_to(97);
        bus.blank_lz = 1'b0;

        // Reset mid-frame discards the pending value
        do_reset();
        load_at(5, 16'h5678);
        run_to(13);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_an", 16'(bus.an), 16'h000F);
        chk("rst_d", 16'(bus.D), 16'h0000);
        chk("rst_ua", 16'(bus.upd_ack), 16'h0000);
        rst_n = 1'b1;
        cur = 0;
        run_to(32);
        chk("rst_ua_c32", 16'(bus.upd_ack), 16'h0000);
        chk("rst_fd_c32", 16'(bus.frame_done), 16'h0001);
        run_to(35);
        chk("rst_d_c35", 16'(bus.D), 16'h0000);
        chk("rst_an_c35", 16'(bus.an), 16'h000E);
        run_to(70);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
